// File: rtl/block_lock_pkg.sv
// Shared types and helpers for the 64b/66b block-lock controller.
package block_lock_pkg;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_WAIT = 2'd2
  } bl_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_stats.sv
// Saturating 16-bit event counters for slips issued and lock losses.
module block_lock_stats (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        slip_i,
  input  logic        loss_i,
  output logic [15:0] slip_total_o,
  output logic [15:0] loss_total_o
);

  logic [15:0] slip_q, loss_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slip_q <= '0;
      loss_q <= '0;
    end else begin
      if (slip_i && (slip_q != 16'hFFFF)) slip_q <= slip_q + 16'd1;
      if (loss_i && (loss_q != 16'hFFFF)) loss_q <= loss_q + 16'd1;
    end
  end

  assign slip_total_o = slip_q;
  assign loss_total_o = loss_q;

endmodule

// File: rtl/block_lock_66.sv
// 64b/66b receive block-lock FSM driving the gearbox slip request.
// Define BLOCK_LOCK_STATS_EN to implement slip/lock-loss statistics counters.
module block_lock_66
  import block_lock_pkg::*;
#(
  parameter int LOCK_CNT         = 64,
  parameter int BAD_MAX          = 16,
  parameter int SLIP_WAIT_BLOCKS = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        lock_en,
  input  logic [1:0]  hdr,
  input  logic        hdr_valid,
  output logic        slip,
  output logic        block_lock,
  output logic [15:0] slip_total,
  output logic [15:0] lock_loss_total
);

  localparam logic [6:0] LOCK_CNT_C  = 7'(LOCK_CNT);
  localparam logic [4:0] BAD_MAX_C   = 5'(BAD_MAX);
  localparam logic [2:0] WAIT_LAST_C = 3'(SLIP_WAIT_BLOCKS - 1);

  bl_state_e  state_q, state_d;
  logic [6:0] sh_cnt_q, sh_cnt_d;
  logic [4:0] invld_cnt_q, invld_cnt_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       slip_q, slip_d;
  logic       lock_q, lock_d;
  logic       hdr_ok;

  assign hdr_ok = sh_is_valid(hdr);

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_d      = 1'b0;
    lock_d      = lock_q;
    if (!lock_en) begin
      state_d = RESET_CNT;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        RESET_CNT: begin
          sh_cnt_d    = '0;
          invld_cnt_d = '0;
          state_d     = TEST_SH;
        end
        TEST_SH: if (hdr_valid) begin
          sh_cnt_d = sh_cnt_q + 7'd1;
          if (!hdr_ok) invld_cnt_d = invld_cnt_q + 5'd1;
          // Lock loss outranks window completion on the same header.
          if (!lock_q) begin
            if (!hdr_ok) begin
              slip_d     = 1'b1;
              wait_cnt_d = '0;
              state_d    = SLIP_WAIT;
            end else if (sh_cnt_d == LOCK_CNT_C) begin
              lock_d  = 1'b1;
              state_d = RESET_CNT;
            end
          end else if (invld_cnt_d == BAD_MAX_C) begin
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            wait_cnt_d = '0;
            state_d    = SLIP_WAIT;
          end else if (sh_cnt_d == LOCK_CNT_C) begin
            state_d = RESET_CNT;
          end
        end
        SLIP_WAIT: if (hdr_valid) begin
          if (wait_cnt_q == WAIT_LAST_C) state_d = RESET_CNT;
          else                           wait_cnt_d = wait_cnt_q + 3'd1;
        end
        default: state_d = RESET_CNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RESET_CNT;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      slip_q      <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      slip_q      <= slip_d;
      lock_q      <= lock_d;
    end
  end

  assign slip       = slip_q;
  assign block_lock = lock_q;

`ifdef BLOCK_LOCK_STATS_EN
  // Disabling the controller is not counted as a lock loss.
  block_lock_stats u_stats (
    .clk          (clk),
    .arst_n       (arst_n),
    .slip_i       (slip_d),
    .loss_i       (lock_q & ~lock_d & lock_en),
    .slip_total_o (slip_total),
    .loss_total_o (lock_loss_total)
  );
`else
  assign slip_total      = 16'h0;
  assign lock_loss_total = 16'h0;
`endif

endmodule

// File: tb/tb_block_lock_66.sv
// Randomized + directed bench for block_lock_66 against a behavioural lock model.
module tb_block_lock_66;

  localparam int LOCK  = 64;
  localparam int BAD   = 16;
  localparam int WAITN = 4;
`ifdef BLOCK_LOCK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, arst_n = 1'b0, lock_en = 1'b0, hdr_valid = 1'b0;
  logic [1:0]  hdr = 2'b01;
  logic        slip, block_lock;
  logic [15:0] slip_total, lock_loss_total;

  int checks = 0, failures = 0, slip_seen = 0;
  bit run_cmp = 1'b0;

  block_lock_66 dut (
    .clk(clk), .arst_n(arst_n), .lock_en(lock_en), .hdr(hdr), .hdr_valid(hdr_valid),
    .slip(slip), .block_lock(block_lock),
    .slip_total(slip_total), .lock_loss_total(lock_loss_total)
  );

  always #5 clk = ~clk;

  // Reference: one "skip" cycle after each restart, a strobe budget while
  // settling after a slip, and header/bad tallies over the current run.
  bit m_lock, m_slip, m_restart, good;
  int m_wait, m_seen, m_bad, m_slips, m_losses;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_lock = 0; m_slip = 0; m_restart = 1; m_wait = 0;
      m_seen = 0; m_bad = 0; m_slips = 0; m_losses = 0;
    end else begin
      m_slip = 0;
      if (!lock_en) begin
        m_lock = 0; m_restart = 1; m_wait = 0;
      end else if (m_restart) begin
        m_restart = 0; m_seen = 0; m_bad = 0;
      end else if (m_wait > 0) begin
        if (hdr_valid) begin
          m_wait--;
          if (m_wait == 0) m_restart = 1;
        end
      end else if (hdr_valid) begin
        good = (hdr == 2'b01) || (hdr == 2'b10);
        m_seen++;
        if (!good) m_bad++;
        if (!m_lock) begin
          if (!good) begin m_slip = 1; m_wait = WAITN; m_slips++; end
          else if (m_seen == LOCK) begin m_lock = 1; m_restart = 1; end
        end else if (m_bad == BAD) begin
          m_lock = 0; m_slip = 1; m_wait = WAITN; m_slips++; m_losses++;
        end else if (m_seen == LOCK) begin
          m_restart = 1;
        end
      end
    end
  end

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (arst_n && run_cmp) begin
      chk("slip", slip, m_slip);
      chk("block_lock", block_lock, m_lock);
      chk("slip_total", slip_total, STATS ? sat(m_slips) : 0);
      chk("lock_loss_total", lock_loss_total, STATS ? sat(m_losses) : 0);
    end
    if (arst_n && slip) slip_seen++;
  end

  task automatic step(input logic [1:0] h, input bit v);
    hdr = h; hdr_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input string nm);
    arst_n = 1'b0; #1;
    chk({nm, "_slip"}, slip, 0);
    chk({nm, "_lock"}, block_lock, 0);
    chk({nm, "_stot"}, slip_total, 0);
    chk({nm, "_ltot"}, lock_loss_total, 0);
    arst_n = 1'b1;
  endtask

  int s0, bad_pct;
  logic [1:0] h;

  initial begin
    lock_en = 1'b1; hdr = 2'b01; hdr_valid = 1'b1;
    #1;
    chk("rst_slip", slip, 0);
    chk("rst_lock", block_lock, 0);
    chk("rst_stot", slip_total, 0);
    chk("rst_ltot", lock_loss_total, 0);
    @(posedge clk); #1;
    arst_n = 1'b1; run_cmp = 1'b1;

    // Clean lock: visible after RESET_CNT cycle + 64 strobes
    repeat (LOCK) step(2'b01, 1);
    chk("clean_pre_lock", block_lock, 0);
    step(2'b01, 1);
    chk("clean_lock", block_lock, 1);
    chk("clean_no_slip", slip_seen, 0);

    // Misaligned start: 5 bad headers, one slip
    pulse_reset("misal_rst");
    s0 = slip_seen;
    step(2'b01, 1);
    step(2'b11, 1);
    chk("misal_slip_hi", slip, 1);
    step(2'b11, 1);
    chk("misal_slip_lo", slip, 0);
    repeat (3) step(2'b11, 1);
    repeat (LOCK) step(2'b01, 1);
    chk("misal_pre_lock", block_lock, 0);
    step(2'b01, 1);
    chk("misal_lock", block_lock, 1);
    chk("misal_one_slip", slip_seen - s0, 1);

    // Window with 15 bad headers keeps lock
    s0 = slip_seen;
    step(2'b01, 1);
    for (int i = 0; i < LOCK; i++) step(((i % 4 == 0) && (i < 60)) ? 2'b00 : 2'b01, 1);
    chk("w15_lock", block_lock, 1);
    chk("w15_no_slip", slip_seen - s0, 0);

    // 16 bad headers drop lock with a slip on the same cycle
    step(2'b01, 1);
    for (int i = 0; i < BAD; i++) begin
      step(2'b00, 1);
      if (i == BAD - 2) chk("w16_lock_held", block_lock, 1);
    end
    chk("w16_lock_drop", block_lock, 0);
    chk("w16_slip", slip, 1);
    chk("w16_loss_tot", lock_loss_total, STATS ? 1 : 0);

    // Relock, then 64th header is the 16th bad one
    repeat (WAITN) step(2'b01, 1);
    repeat (LOCK + 1) step(2'b01, 1);
    chk("relock", block_lock, 1);
    step(2'b01, 1);
    for (int i = 0; i < LOCK; i++) step((i >= LOCK - BAD) ? 2'b11 : 2'b01, 1);
    chk("simul_drop", block_lock, 0);
    chk("simul_slip", slip, 1);

    // Reset during SLIP_WAIT with slip in flight
    pulse_reset("mid_rst");
    repeat (LOCK + 1) step(2'b10, 1);
    chk("post_rst_lock", block_lock, 1);

    // lock_en drop while locked
    lock_en = 1'b0;
    step(2'b01, 1);
    chk("en_lock", block_lock, 0);
    chk("en_slip", slip, 0);
    chk("en_stot", slip_total, 0);
    chk("en_ltot", lock_loss_total, 0);
    lock_en = 1'b1;

    // Randomized phases with varying bad-header density
    bad_pct = 0;
    for (int n = 0; n < 6000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    bad_pct = 0;
          2:       bad_pct = 3;
          3:       bad_pct = 30;
          default: bad_pct = 80;
        endcase
      end
      lock_en = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 1999) == 0) pulse_reset("rnd_rst");
      if ($urandom_range(0, 99) < bad_pct) h = $urandom_range(0, 1) ? 2'b00 : 2'b11;
      else                                 h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      step(h, $urandom_range(0, 9) < 8);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
